// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared types and defaults.
// Defaults are shared with the FIFO instance at the lab top.
package fifo_reader_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST      = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/fifo_reader.sv
// fifo_reader: pops BURST words from the FIFO, streams them out,
// and reports their running sum with a one-cycle done pulse.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST      = DEF_BURST,
    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic                  fifo_wren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rden,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [SUM_WIDTH-1:0]  sum,
    output logic                  done,
    output logic                  busy
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(BURST);

    if (BURST < 1 || BURST > 255) begin : g_bad_burst
        $error("fifo_reader: BURST must be 1..255");
    end

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          pop_ok;

    // A pop only lands when the writer is not using the FIFO this cycle.
    assign fifo_rden = (state == REQ) && !fifo_empty;
    assign pop_ok    = fifo_rden && !fifo_wren;
    assign o_valid   = (state == HOLD);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

    // Next-state decode.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (pop_ok) state_d = CAPT;
            CAPT:    state_d = HOLD;
            HOLD: begin
                if (o_ready) state_d = (cnt == LAST) ? DONE : REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, word counter, accumulator and output word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sum    <= '0;
            o_data <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                cnt <= '0;
                sum <= '0;
            end
            if (state == CAPT) begin
                o_data <= fifo_rdata;
                sum    <= sum + SUM_WIDTH'(fifo_rdata);
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Burst consumer for the 8-deep shift-register FIFO. On a start pulse it pops exactly BURST words from the FIFO and presents each word downstream on a valid/ready stream. It keeps an unsigned running sum of the words and reports that sum with a one-cycle done pulse. It sits on the read side of the FIFO, opposite the producer that drives the FIFO's write port.

## Interface
- DATA_WIDTH, 8, word width; matches the FIFO data width
- BURST, 8, words popped per start; must be 1..255
- SUM_WIDTH (localparam), DATA_WIDTH+$clog2(BURST+1), accumulator width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- start  in  1  single-cycle request; ignored unless in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_wren  in  1  tap of the FIFO writer's write enable; used to detect rejected pops
- fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rden
- fifo_rden  out  1  FIFO pop request
- o_data  out  DATA_WIDTH  current output word; registered
- o_valid  out  1  o_data valid
- o_ready  in  1  downstream accept
- sum  out  SUM_WIDTH  running sum of words popped in the current burst
- done  out  1  one-cycle pulse after the last word is accepted downstream
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, REQ, CAPT, HOLD, DONE.
- IDLE
  - start=1 → REQ.
  - On that transition, clear the word counter cnt and clear sum.
- REQ
  - fifo_rden = !fifo_empty, combinational, asserted only in this state.
  - A pop is accepted when fifo_rden=1 and fifo_wren=0 in the same cycle → CAPT.
  - fifo_rden=1 with fifo_wren=1: the FIFO gives write priority and does not pop, but it still drives its head word. Stay in REQ, ignore the next cycle's fifo_rdata, and retry.
  - fifo_empty=1: stay in REQ with fifo_rden=0. No timeout.
- CAPT
  - o_data <= fifo_rdata.
  - sum <= sum + fifo_rdata, zero-extended to SUM_WIDTH.
  - cnt <= cnt+1.
  - → HOLD.
- HOLD
  - o_valid=1; o_data held stable until accepted.
  - o_ready=1 and cnt==BURST → DONE.
  - o_ready=1 and cnt<BURST → REQ.
- DONE
  - done=1 for exactly one cycle → IDLE.
  - sum keeps its final value until the next start.
- A start that arrives in any state other than IDLE is dropped. It is not queued.
- Arithmetic: unsigned. sum cannot overflow at the maximum BURST×(2^DATA_WIDTH−1).
- fifo_rden is never asserted outside REQ. At most one pop is outstanding.

## Timing
- Reset values: state=IDLE, fifo_rden=0, o_data=0, o_valid=0, sum=0, done=0, busy=0, cnt=0.
- rst takes priority over every input. Reset mid-burst returns to IDLE without a done pulse. Words already popped are discarded.
- Cycle-level sequence with the FIFO non-empty, no write collisions, and o_ready tied high:
  - start sampled at cycle 0.
  - REQ with fifo_rden=1 in cycle 1.
  - CAPT in cycle 2 (fifo_rdata valid).
  - o_valid=1 in cycle 3.
  - Next REQ in cycle 4.
- Throughput is 1 word per 3 cycles. The last word is accepted in cycle 3·BURST, and done is high in cycle 3·BURST+1.
- Each o_ready stall cycle in HOLD adds one cycle. Each rejected pop or empty cycle in REQ adds one cycle.
- busy rises the cycle after start is sampled and falls the cycle after done.

## Structure
- Shared package fifo_reader_pkg contains:
  - typedef enum logic [2:0] state_t {IDLE, REQ, CAPT, HOLD, DONE}.
  - Default DATA_WIDTH/BURST constants shared with the FIFO instance.
- Single flat module with no sub-module. The counter, accumulator and FSM are small enough to live together.
- The FIFO is instantiated alongside this block at the lab top, not inside it.

## Test plan
- Basic burst, BURST=4
  - Stimulus: preload FIFO with 0x01,0x02,0x03,0x04; pulse start; o_ready=1.
  - Response: o_data 1,2,3,4 in cycles 3,6,9,12; done in cycle 13; sum=10; FIFO empty afterwards.
- Backpressure
  - Stimulus: hold o_ready=0 for 5 cycles on the second word 0xAA.
  - Response: o_data stays 0xAA with o_valid=1 throughout; no fifo_rden while in HOLD; final sum unchanged.
- Empty stall
  - Stimulus: start with FIFO empty; write 0x7F at cycle 6.
  - Response: fifo_rden=0 until fifo_empty falls; the word is captured afterwards; no spurious output.
- Write collision
  - Stimulus: drive fifo_wren=1 in the same cycle as the first fifo_rden.
  - Response: the pop is rejected; no duplicate word on the output; the word sequence still matches FIFO order.
- Overflow bound, BURST=8
  - Stimulus: eight 0xFF words.
  - Response: sum=0x7F8 (SUM_WIDTH=12); done pulses exactly once.
- Reset and dropped start
  - Stimulus: assert rst during HOLD of word 2; pulse start while busy.
  - Response: all outputs return to reset values next cycle; no done; start while busy is ignored; a new start after reset runs a full burst.
